// File: rtl/decode_pkg.sv
// Shared types and constants for the polynomial decode scheduler.
// Holds the FSM encoding, level codes and per-level output sizing.
package decode_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FEED,
    S_DRAIN,
    S_WAIT_RDY,
    S_FIN
  } state_t;

  localparam logic [1:0] LVL_640  = 2'd0;
  localparam logic [1:0] LVL_976  = 2'd1;
  localparam logic [1:0] LVL_1344 = 2'd2;
  localparam logic [1:0] LVL_BAD  = 2'd3;

  localparam int BATCHES         = 4;
  localparam int WORDS_PER_BATCH = 16;

  // Packed output words produced per batch at a given level.
  function automatic logic [2:0] out_words(input logic [1:0] lvl);
    case (lvl)
      LVL_640: return 3'd2;
      LVL_976: return 3'd3;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/decode_sched.sv
// Decode scheduler: streams 4x16 coefficient words into the decode
// datapath and writes its packed batch results to the result RAM.
module decode_sched
  import decode_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [1:0]  sec_lvl,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        rd_en,
  output logic [5:0]  rd_addr,
  input  logic [63:0] rd_data,
  output logic [1:0]  dec_sec_lvl,
  output logic [63:0] dec_msg,
  output logic        dec_msg_val,
  input  logic        dec_ready,
  input  logic [63:0] dec_out,
  input  logic        dec_out_val,
  output logic        wr_en,
  output logic [3:0]  wr_addr,
  output logic [63:0] wr_data
);

  state_t     state;
  state_t     state_nxt;
  logic [1:0] batch;
  logic [3:0] word_cnt;
  logic [1:0] out_cnt;
  logic [1:0] lvl_q;
  logic [2:0] n_words;
  logic       accept;
  logic       last_word;
  logic       last_out;
  logic       last_batch;
  logic       err_nxt;

  assign n_words    = out_words(lvl_q);
  assign last_word  = word_cnt == 4'(WORDS_PER_BATCH - 1);
  assign last_out   = {1'b0, out_cnt} == n_words - 3'd1;
  assign last_batch = batch == 2'(BATCHES - 1);

  assign rd_addr     = {batch, word_cnt};
  assign dec_sec_lvl = lvl_q;
  assign dec_msg     = dec_msg_val ? rd_data : '0;
  assign wr_data     = dec_out;

  // Bad level on an idle start, or a result word arriving when no
  // batch is draining, are both reported as a single-cycle error.
  assign err_nxt = (state == S_IDLE && start && sec_lvl == LVL_BAD)
                 || (dec_out_val && state != S_DRAIN);

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state and per-state strobes.
  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    accept    = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start && sec_lvl != LVL_BAD) begin
          accept    = 1'b1;
          state_nxt = S_FEED;
        end
      end
      S_FEED: begin
        rd_en = dec_ready;
        if (dec_ready && last_word) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        wr_en = dec_out_val;
        if (dec_out_val && last_out)
          state_nxt = last_batch ? S_FIN : S_WAIT_RDY;
      end
      S_WAIT_RDY: begin
        if (dec_ready) state_nxt = S_FEED;
      end
      S_FIN: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Batch, word, output and write-address counters; the last write of
  // the last batch leaves wr_addr on its final address.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      batch    <= '0;
      word_cnt <= '0;
      out_cnt  <= '0;
      wr_addr  <= '0;
      lvl_q    <= '0;
    end else if (accept) begin
      batch    <= '0;
      word_cnt <= '0;
      out_cnt  <= '0;
      wr_addr  <= '0;
      lvl_q    <= sec_lvl;
    end else begin
      if (rd_en) word_cnt <= word_cnt + 4'd1;
      if (wr_en) begin
        if (last_out) begin
          out_cnt <= '0;
          if (!last_batch) batch <= batch + 2'd1;
        end else begin
          out_cnt <= out_cnt + 2'd1;
        end
        if (!(last_out && last_batch)) wr_addr <= wr_addr + 4'd1;
      end
    end
  end

  // RAM data lands one cycle after the read; valid and error follow.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dec_msg_val <= 1'b0;
      err         <= 1'b0;
    end else begin
      dec_msg_val <= rd_en;
      err         <= err_nxt;
    end
  end

endmodule

// File: tb/tb_decode_sched.sv
// Bench for decode_sched: RAM and decode-datapath models driven per
// cycle, a table of polynomial runs and a few hand sequences.
module tb_decode_sched;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [1:0]  sec_lvl;
  logic        busy;
  logic        done;
  logic        err;
  logic        rd_en;
  logic [5:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  dec_sec_lvl;
  logic [63:0] dec_msg;
  logic        dec_msg_val;
  logic        dec_ready;
  logic [63:0] dec_out;
  logic        dec_out_val;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [63:0] wr_data;

  decode_sched dut (
    .clk(clk), .rstn(rstn), .start(start), .sec_lvl(sec_lvl),
    .busy(busy), .done(done), .err(err),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .dec_sec_lvl(dec_sec_lvl), .dec_msg(dec_msg),
    .dec_msg_val(dec_msg_val), .dec_ready(dec_ready),
    .dec_out(dec_out), .dec_out_val(dec_out_val),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] lvl;
    int         stall_at;
    int         stall_len;
    bit         busy_start;
    int         exp_reads;
    int         exp_writes;
    int         exp_done;
    int         exp_err;
    int         exp_stall;
  } vec_t;

  int errors = 0;
  int checks = 0;

  int reads, msgs, writes, dones, errs, stalled;
  int exp_wr, out_idx, pend, batch_msg, n_cur;
  int stall_rem, stall_at, stall_len;
  int cyc, last_wr_cyc, done_cyc;
  bit exp_err_q, m_busy, inject, do_start;
  logic [1:0]  start_lvl, cur_lvl;
  logic [63:0] rd_next;

  function automatic logic [63:0] pat_in(int a);
    return {4{16'(a * 3 + 1)}} ^ 64'hA5A5_0F0F_3C3C_9696;
  endfunction

  function automatic logic [63:0] pat_out(int i);
    return 64'hC0DE_0000_0000_0000 | 64'(i);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic clear_model();
    reads = 0; msgs = 0; writes = 0; dones = 0; errs = 0;
    stalled = 0; exp_wr = 0; out_idx = 0; pend = 0;
    batch_msg = 0; stall_rem = 0; stall_at = 0; stall_len = 0;
    last_wr_cyc = -10; done_cyc = -1;
    exp_err_q = 0; m_busy = 0; inject = 0; do_start = 0;
  endtask

  task automatic init_run(logic [1:0] lvl, int s_at, int s_len);
    clear_model();
    n_cur     = 2 + int'(lvl);
    cur_lvl   = lvl;
    stall_at  = s_at;
    stall_len = s_len;
    do_start  = 1;
    start_lvl = lvl;
  endtask

  // One clock: drive inputs at the falling edge, then observe what the
  // next rising edge will commit.
  task automatic cycle();
    @(negedge clk);
    start    = do_start;
    sec_lvl  = start_lvl;
    do_start = 0;
    dec_ready = (stall_rem == 0);
    if (stall_rem > 0) stall_rem--;
    if (inject) begin
      dec_out_val = 1'b1;
      dec_out     = 64'hDEAD_BEEF_0000_0001;
    end else if (pend > 0) begin
      dec_out_val = 1'b1;
      dec_out     = pat_out(out_idx);
      out_idx++;
      pend--;
    end else begin
      dec_out_val = 1'b0;
    end
    #1;
    cyc++;
    rd_next = rd_data;
    if (!dec_ready) begin
      chk("rd_en_stall", rd_en, 1'b0);
      if (m_busy) stalled++;
    end
    if (rd_en) begin
      chk("rd_addr", rd_addr, reads);
      rd_next = pat_in(reads);
      reads++;
      if (stall_len > 0 && reads == stall_at) stall_rem = stall_len;
    end
    if (dec_msg_val) begin
      chk("dec_msg", dec_msg, pat_in(msgs));
      msgs++;
      batch_msg++;
      if (batch_msg == 16) begin
        batch_msg = 0;
        pend = n_cur;
      end
    end
    if (dec_out_val) begin
      chk("wr_en", wr_en, !inject);
      if (wr_en) begin
        chk("wr_addr", wr_addr, exp_wr);
        chk("wr_data", wr_data, dec_out);
        exp_wr++;
        writes++;
        last_wr_cyc = cyc;
      end
    end
    chk("err", err, exp_err_q);
    if (err) errs++;
    exp_err_q = (start && sec_lvl == 2'd3 && !m_busy) || inject;
    if (m_busy) begin
      chk("busy", busy, 1'b1);
      chk("dec_sec_lvl", dec_sec_lvl, cur_lvl);
    end
    if (done) begin
      dones++;
      done_cyc = cyc;
      m_busy = 0;
    end
    if (start && sec_lvl != 2'd3 && !m_busy) m_busy = 1;
    rd_data = rd_next;
    inject  = 0;
  endtask

  task automatic wait_done(int budget);
    int n = 0;
    while (dones == 0 && n < budget) begin
      cycle();
      n++;
    end
    if (dones == 0) chk("done_timeout", 1'b0, 1'b1);
  endtask

  task automatic reset_checks();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_rd_en", rd_en, 1'b0);
    chk("rst_rd_addr", rd_addr, 6'd0);
    chk("rst_msg_val", dec_msg_val, 1'b0);
    chk("rst_msg", dec_msg, 64'd0);
    chk("rst_sec_lvl", dec_sec_lvl, 2'd0);
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_wr_addr", wr_addr, 4'd0);
  endtask

  task automatic run_vec(vec_t v);
    bit did = 0;
    int n = 0;
    init_run(v.lvl, v.stall_at, v.stall_len);
    cycle();
    if (v.lvl == 2'd3) begin
      repeat (6) cycle();
    end else begin
      while (dones == 0 && n < 3000) begin
        if (v.busy_start && reads == 10 && !did) begin
          do_start  = 1;
          start_lvl = 2'd3;
          did = 1;
        end
        cycle();
        n++;
      end
      if (dones == 0) chk("done_timeout", 1'b0, 1'b1);
    end
    cycle();
    chk("busy_after", busy, 1'b0);
    chk("n_reads", reads, v.exp_reads);
    chk("n_msgs", msgs, v.exp_reads);
    chk("n_writes", writes, v.exp_writes);
    chk("n_done", dones, v.exp_done);
    chk("n_err", errs, v.exp_err);
    chk("n_stall", stalled, v.exp_stall);
    if (v.exp_done > 0)
      chk("done_after_last_wr", done_cyc, last_wr_cyc + 1);
  endtask

  vec_t vecs[5];

  initial begin
    cyc = 0;
    clear_model();
    start_lvl = 0;
    cur_lvl   = 0;
    n_cur     = 2;
    rstn = 1'b0; start = 1'b0; sec_lvl = 2'd0;
    rd_data = '0; dec_ready = 1'b1;
    dec_out = '0; dec_out_val = 1'b0;

    vecs[0] = '{2'd0, 0, 0, 1'b0, 64, 8, 1, 0, 0};
    vecs[1] = '{2'd2, 0, 0, 1'b0, 64, 16, 1, 0, 0};
    vecs[2] = '{2'd1, 24, 5, 1'b0, 64, 12, 1, 0, 5};
    vecs[3] = '{2'd3, 0, 0, 1'b0, 0, 0, 0, 1, 0};
    vecs[4] = '{2'd1, 0, 0, 1'b1, 64, 12, 1, 0, 0};

    #2;
    reset_checks();
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Abort during batch 2 drain, then restart cleanly.
    begin
      int n = 0;
      init_run(2'd0, 0, 0);
      while (writes < 5 && n < 1000) begin
        cycle();
        n++;
      end
      chk("abort_reached", writes, 5);
      @(negedge clk);
      #2;
      rstn = 1'b0;
      start = 1'b0;
      dec_out_val = 1'b0;
      #1;
      reset_checks();
      @(negedge clk);
      rstn = 1'b1;
      clear_model();
      repeat (4) cycle();
      chk("no_done_abort", dones, 0);
      run_vec(vecs[0]);
    end

    // Stray result word during feed.
    begin
      int n = 0;
      init_run(2'd0, 0, 0);
      while (reads < 5 && n < 100) begin
        cycle();
        n++;
      end
      inject = 1;
      cycle();
      cycle();
      wait_done(3000);
      chk("inj_err", errs, 1);
      chk("inj_writes", writes, 8);
      chk("inj_done", dones, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decode_sched.md
DECODE_SCHED -- requirements
Module: decode_sched

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 rstn  in  1  reset, asynchronous, active-low.
REQ-003 start  in  1  one-cycle request to decode one polynomial; sampled only in IDLE.
REQ-004 sec_lvl  in  2  security level: 0/1/2 valid, 3 illegal; latched on accepted start.
REQ-005 busy  out  1  high in every state except IDLE.
REQ-006 done  out  1  one-cycle pulse when the last output word is written.
REQ-007 err  out  1  one-cycle pulse on start with sec_lvl==3, or on dec_out_val outside DRAIN.
REQ-008 rd_en / rd_addr  out  1 / 6  read strobe and word address of the source coefficient RAM; the RAM returns data one cycle after rd_en.
REQ-009 rd_data  in  64  RAM read data, 4 coefficients x 16 bits.
REQ-010 dec_sec_lvl  out  2  latched level driven to the decode datapath; constant while busy.
REQ-011 dec_msg / dec_msg_val  out  64 / 1  word and valid to the decode datapath.
REQ-012 dec_ready  in  1  decode datapath is in its receive phase.
REQ-013 dec_out / dec_out_val  in  64 / 1  packed output word and valid from the decode datapath.
REQ-014 wr_en / wr_addr / wr_data  out  1 / 4 / 64  write port of the packed result RAM.

Function
REQ-015 States: IDLE, FEED, DRAIN, WAIT_RDY, FIN.
- Transitions:
  - IDLE->FEED on start with sec_lvl!=3.
  - FEED->DRAIN after the 16th read is issued.
  - DRAIN->WAIT_RDY after N output words of a batch that is not batch 3.
  - DRAIN->FIN after N output words of batch 3.
  - WAIT_RDY->FEED when dec_ready is high.
  - FIN->IDLE unconditionally.
- N is 2, 3 or 4 for sec_lvl 0, 1 or 2.
REQ-016 Start handling:
- start with sec_lvl==3 in IDLE: pulse err; stay in IDLE.
- start while busy: ignored; no err.
REQ-017 Batches and reads:
- One polynomial is 4 batches x 16 words (rd_addr 0..63).
- In FEED, rd_en is high every cycle that dec_ready is high, with rd_addr = batch*16 + word_cnt.
- word_cnt increments per read and wraps 15->0 on entry to DRAIN.
REQ-018 Feed path: dec_msg = rd_data and dec_msg_val = rd_en delayed one cycle; exactly 16 valids per batch, none outside.
REQ-019 Write path:
- wr_en = dec_out_val while in DRAIN; wr_data = dec_out, combinational.
- wr_addr starts at 0 on start and increments per write, ending at 8/12/16 total words minus 1 (7/11/15).
REQ-020 done: pulses in the FIN cycle; busy drops the following cycle.
REQ-021 Stray output: dec_out_val in FEED or WAIT_RDY pulses err and is not written.
REQ-022 dec_ready low inside FEED stalls reads without losing word_cnt; the read resumes when dec_ready returns.
REQ-023 All counters are bounded: batch 0..3, word_cnt 0..15, out_cnt 0..N-1; none wraps while busy.

Reset
REQ-024 rstn low:
- Forces IDLE.
- Clears batch, word_cnt, out_cnt, wr_addr and the latched sec_lvl.
- Drives busy, done, err, rd_en, dec_msg_val and wr_en low; rd_addr, dec_msg and dec_sec_lvl to 0.
REQ-025 Reset mid-operation abandons the polynomial; no done pulse follows; the next start begins at batch 0, wr_addr 0.

Structure
REQ-026 Shared package decode_pkg holds:
- the state enumeration;
- level constants LVL_640=0, LVL_976=1, LVL_1344=2;
- BATCHES=4 and WORDS_PER_BATCH=16;
- the N lookup function (2/3/4).
REQ-027 No sub-module: the decode datapath is instantiated beside this block at the top level, not inside it; counters and FSM are inline.

Verification
REQ-028 sec_lvl=0, start, dec_ready held high by a model:
- 64 reads at addresses 0..63 and 64 dec_msg_val;
- 8 writes at wr_addr 0..7;
- one done pulse.
REQ-029 sec_lvl=2: 16 writes at wr_addr 0..15, 4 per batch; done after the write to address 15.
REQ-030 sec_lvl=3 start -> err one cycle, busy stays 0, no rd_en.
REQ-031 sec_lvl=1, dec_ready dropped for 5 cycles after read 7 of batch 1:
- rd_en stalls for those cycles;
- addresses continue 24..31 with no skip or duplicate;
- 12 writes total.
REQ-032 rstn asserted during batch 2 DRAIN, then a new start at sec_lvl=0 -> rd_addr restarts at 0, wr_addr at 0, no done from the aborted run.
REQ-033 dec_out_val injected during FEED -> err pulse; wr_en stays 0 that cycle.
